// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_stage_pkg;

    localparam int               XLEN          = 32;
    localparam logic [XLEN-1:0]  NOP_INSTR_DEF = 32'h0000_0000;
    localparam logic [XLEN-1:0]  RESET_PC_DEF  = 32'h0000_0000;
    localparam logic [XLEN-1:0]  PC_INC        = 32'd4;

    typedef enum logic [2:0] {
        SEL_SEQ,
        SEL_BRANCH,
        SEL_JUMPR,
        SEL_JUMP,
        SEL_HOLD
    } pc_sel_e;

    // Redirect targets are word addresses; the low two bits are dropped.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
        return {a[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: hazard controls, redirects, instruction memory and IF/ID outputs.
// Controls and redirects are level signals sampled on every rising clock edge; there is no handshake.
interface fetch_stage_if #(
    parameter int CNT_W = 16
);
    import fetch_stage_pkg::*;

    logic             PC_write;
    logic             IFID_write;
    logic             IFID_flush;
    logic             branch_sel;
    logic [XLEN-1:0]  branch_target;
    logic             Jump;
    logic             JumpAL;
    logic [XLEN-1:0]  jump_target;
    logic             JumpR;
    logic [XLEN-1:0]  jumpr_target;
    logic [XLEN-1:0]  imem_addr;
    logic [XLEN-1:0]  imem_data;
    logic [XLEN-1:0]  IFID_pc4;
    logic [XLEN-1:0]  IFID_instr;
    logic             IFID_valid;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;

    modport slave (
        input  PC_write, IFID_write, IFID_flush,
        input  branch_sel, branch_target, Jump, JumpAL, jump_target, JumpR, jumpr_target,
        input  imem_data,
        output imem_addr, IFID_pc4, IFID_instr, IFID_valid, stall_count, flush_count
    );

    modport master (
        output PC_write, IFID_write, IFID_flush,
        output branch_sel, branch_target, Jump, JumpAL, jump_target, JumpR, jumpr_target,
        output imem_data,
        input  imem_addr, IFID_pc4, IFID_instr, IFID_valid, stall_count, flush_count
    );

endinterface

// File: rtl/fetch_stage_ifid_reg.sv
// IF/ID pipeline register: flush inserts a bubble, write captures, otherwise holds.
module ifid_reg
    import fetch_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush_i,
    input  logic            write_i,
    input  logic [XLEN-1:0] instr_i,
    input  logic [XLEN-1:0] pc4_i,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] pc4_o,
    output logic            valid_o
);

    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] pc4_q, pc4_d;
    logic            valid_q, valid_d;

    always_comb begin
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        if (flush_i) begin
            instr_d = NOP_INSTR;
            pc4_d   = '0;
            valid_d = 1'b0;
        end else if (write_i) begin
            instr_d = instr_i;
            pc4_d   = pc4_i;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_q <= NOP_INSTR;
            pc4_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
        end
    end

    assign instr_o = instr_q;
    assign pc4_o   = pc4_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: PC register, next-PC select, IF/ID register and saturating debug counters.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEF,
    parameter int              CNT_W     = 16,
    parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input logic           clk,
    input logic           reset,
    fetch_stage_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [XLEN-1:0]  pc_q, pc_d;
    logic [XLEN-1:0]  pc_plus4;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             redirect;
    logic             stall_evt;
    pc_sel_e          pc_sel;
    logic [XLEN-1:0]  ifid_instr;
    logic [XLEN-1:0]  ifid_pc4;
    logic             ifid_valid;

    assign pc_plus4  = pc_q + PC_INC;
    assign redirect  = bus.branch_sel | bus.JumpR | bus.Jump | bus.JumpAL;
    // A redirect comes from an older instruction, so it wins over a load-use stall.
    assign stall_evt = ~bus.PC_write & ~redirect;

    always_comb begin
        pc_sel = SEL_HOLD;
        if (bus.branch_sel)             pc_sel = SEL_BRANCH;
        else if (bus.JumpR)             pc_sel = SEL_JUMPR;
        else if (bus.Jump | bus.JumpAL) pc_sel = SEL_JUMP;
        else if (bus.PC_write)          pc_sel = SEL_SEQ;
    end

    always_comb begin
        pc_d = pc_q;
        case (pc_sel)
            SEL_BRANCH: pc_d = word_align(bus.branch_target);
            SEL_JUMPR:  pc_d = word_align(bus.jumpr_target);
            SEL_JUMP:   pc_d = word_align(bus.jump_target);
            SEL_SEQ:    pc_d = pc_plus4;
            default:    pc_d = pc_q;
        endcase
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_evt && (stall_cnt_q != CNT_MAX))
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        if (bus.IFID_flush && (flush_cnt_q != CNT_MAX))
            flush_cnt_d = flush_cnt_q + CNT_ONE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q        <= RESET_PC;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            pc_q        <= pc_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    ifid_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_ifid_reg (
        .clk     (clk),
        .reset   (reset),
        .flush_i (bus.IFID_flush),
        .write_i (bus.IFID_write),
        .instr_i (bus.imem_data),
        .pc4_i   (pc_plus4),
        .instr_o (ifid_instr),
        .pc4_o   (ifid_pc4),
        .valid_o (ifid_valid)
    );

    assign bus.imem_addr   = pc_q;
    assign bus.IFID_instr  = ifid_instr;
    assign bus.IFID_pc4    = ifid_pc4;
    assign bus.IFID_valid  = ifid_valid;
    assign bus.stall_count = stall_cnt_q;
    assign bus.flush_count = flush_cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed hazard scenarios plus random traffic against a reference model.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  localparam int          CNT_W   = 16;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;
  localparam logic [31:0] RST_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP     = 32'h0000_0000;

  logic clk;
  logic reset;

  fetch_stage_if #(.CNT_W(CNT_W)) bus ();

  fetch_stage #(
    .RESET_PC  (RST_PC),
    .CNT_W     (CNT_W),
    .NOP_INSTR (NOP)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // combinational instruction memory, content derived from the address
  function automatic logic [31:0] imem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h2001_0005;
    return {a[15:0] ^ 16'h1234, a[31:16] ^ 16'hBEEF} | 32'h1;
  endfunction

  assign bus.imem_data = imem_word(bus.imem_addr);

  // reference model state
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_pc4;
  logic        m_valid;
  int          m_stall;
  int          m_flush;

  int checks;
  int failures;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%08h exp=%08h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string ph);
    chk({ph, ".imem_addr"}, bus.imem_addr, m_pc);
    chk({ph, ".instr"}, bus.IFID_instr, m_instr);
    chk({ph, ".pc4"}, bus.IFID_pc4, m_pc4);
    chk({ph, ".valid"}, {31'b0, bus.IFID_valid}, {31'b0, m_valid});
    chk({ph, ".stall_cnt"}, {16'b0, bus.stall_count}, m_stall[31:0]);
    chk({ph, ".flush_cnt"}, {16'b0, bus.flush_count}, m_flush[31:0]);
  endtask

  task automatic model_reset();
    m_pc    = RST_PC;
    m_instr = NOP;
    m_pc4   = 32'h0;
    m_valid = 1'b0;
    m_stall = 0;
    m_flush = 0;
  endtask

  // one clock of the architectural rules, applied to the current inputs
  task automatic model_update();
    logic any_redirect;
    logic [31:0] nxt;
    any_redirect = bus.branch_sel || bus.JumpR || bus.Jump || bus.JumpAL;
    if (bus.IFID_flush) begin
      m_instr = NOP;
      m_pc4   = 32'h0;
      m_valid = 1'b0;
    end else if (bus.IFID_write) begin
      m_instr = imem_word(m_pc);
      m_pc4   = m_pc + 32'd4;
      m_valid = 1'b1;
    end
    if (!bus.PC_write && !any_redirect && m_stall < CNT_MAX) m_stall++;
    if (bus.IFID_flush && m_flush < CNT_MAX) m_flush++;
    if (bus.branch_sel)              nxt = bus.branch_target & ~32'h3;
    else if (bus.JumpR)              nxt = bus.jumpr_target & ~32'h3;
    else if (bus.Jump || bus.JumpAL) nxt = bus.jump_target & ~32'h3;
    else if (bus.PC_write)           nxt = m_pc + 32'd4;
    else                             nxt = m_pc;
    m_pc = nxt;
  endtask

  // driver tasks
  task automatic drive(input logic pw, input logic iw, input logic fl);
    bus.PC_write   = pw;
    bus.IFID_write = iw;
    bus.IFID_flush = fl;
    bus.branch_sel = 1'b0;
    bus.Jump       = 1'b0;
    bus.JumpAL     = 1'b0;
    bus.JumpR      = 1'b0;
  endtask

  task automatic drive_redirect(input logic br, input logic [31:0] bt,
                                input logic j, input logic jal, input logic [31:0] jt,
                                input logic jr, input logic [31:0] jrt);
    bus.branch_sel    = br;
    bus.branch_target = bt;
    bus.Jump          = j;
    bus.JumpAL        = jal;
    bus.jump_target   = jt;
    bus.JumpR         = jr;
    bus.jumpr_target  = jrt;
  endtask

  task automatic step(input bit do_chk, input string ph);
    model_update();
    @(posedge clk);
    #1;
    if (do_chk) check_all(ph);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    drive_redirect(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    model_reset();
    #1;
    check_all("reset");
    @(posedge clk);
    #1;
    reset = 1'b0;

    // first fetch from reset PC
    drive(1'b1, 1'b1, 1'b0);
    step(1'b1, "first");
    chk("first.instr_word", bus.IFID_instr, 32'h2001_0005);
    chk("first.addr4", bus.imem_addr, 32'h4);

    // advance to 0x10, then a one-cycle load-use stall
    while (m_pc != 32'h10) step(1'b1, "seq");
    drive(1'b0, 1'b0, 1'b0);
    step(1'b1, "stall");
    chk("stall.pc_held", bus.imem_addr, 32'h10);
    drive(1'b1, 1'b1, 1'b0);
    step(1'b1, "resume");
    chk("resume.addr", bus.imem_addr, 32'h14);

    // jump to 0x20 then taken branch with flush
    drive(1'b1, 1'b1, 1'b0);
    drive_redirect(1'b0, 32'h0, 1'b1, 1'b0, 32'h20, 1'b0, 32'h0);
    step(1'b1, "jump");
    drive(1'b1, 1'b1, 1'b1);
    drive_redirect(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    step(1'b1, "branch_flush");
    chk("branch_flush.addr", bus.imem_addr, 32'h100);

    // redirect overrides stall
    drive(1'b0, 1'b0, 1'b0);
    drive_redirect(1'b1, 32'h200, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    step(1'b1, "br_over_stall");

    // priority among simultaneous redirects
    drive(1'b1, 1'b1, 1'b0);
    drive_redirect(1'b1, 32'h40, 1'b1, 1'b1, 32'hC0, 1'b1, 32'h80);
    step(1'b1, "prio");
    chk("prio.addr", bus.imem_addr, 32'h40);
    drive(1'b1, 1'b1, 1'b0);
    drive_redirect(1'b0, 32'h0, 1'b1, 1'b0, 32'hC0, 1'b1, 32'h83);
    step(1'b1, "jr_align");
    chk("jr_align.addr", bus.imem_addr, 32'h80);
    drive(1'b1, 1'b1, 1'b0);
    drive_redirect(1'b0, 32'h0, 1'b0, 1'b1, 32'h1_0002, 1'b0, 32'h0);
    step(1'b1, "jal");

    // PC wrap: JAL to 0xFFFFFFFF aligns to 0xFFFFFFFC, then sequential
    drive(1'b1, 1'b1, 1'b0);
    drive_redirect(1'b0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'h0);
    step(1'b1, "to_top");
    chk("to_top.addr", bus.imem_addr, 32'hFFFF_FFFC);
    drive(1'b1, 1'b1, 1'b0);
    step(1'b1, "wrap");
    chk("wrap.addr", bus.imem_addr, 32'h0);
    chk("wrap.pc4", bus.IFID_pc4, 32'h0);

    // flush with IFID_write=0 still bubbles; long stall+flush run saturates both counters
    drive(1'b0, 1'b0, 1'b1);
    step(1'b1, "flush_nowrite");
    for (int i = 0; i < CNT_MAX + 4; i++) step(1'b0, "sat");
    check_all("sat");
    chk("sat.stall_max", {16'b0, bus.stall_count}, 32'h0000_FFFF);
    step(1'b1, "sat_more");
    chk("sat_more.flush_max", {16'b0, bus.flush_count}, 32'h0000_FFFF);

    // asynchronous reset between edges while a redirect is pending
    drive(1'b1, 1'b1, 1'b0);
    drive_redirect(1'b1, 32'h300, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    @(posedge clk);
    #1;
    check_all("rst_held");
    reset = 1'b0;
    drive(1'b1, 1'b1, 1'b0);
    drive_redirect(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    step(1'b1, "post_rst");
    chk("post_rst.pc4", bus.IFID_pc4, 32'h4);

    // random traffic
    for (int i = 0; i < 2000; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0);
      drive_redirect($urandom_range(0, 9) == 0, $urandom(),
                     $urandom_range(0, 11) == 0, $urandom_range(0, 11) == 0, $urandom(),
                     $urandom_range(0, 11) == 0, $urandom());
      step(1'b1, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
